// File: rtl/watch_pkg.sv
// Shared types and constants for the watch mode sequencer.
package watch_pkg;

  typedef enum logic [1:0] {
    NORM   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } watch_state_e;

  localparam int DISP_W = 48;

  localparam int MODE_CLOCK     = 0;
  localparam int MODE_ALARM     = 1;
  localparam int MODE_STOPWATCH = 2;
  localparam int MODE_TIMER     = 3;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_ENTER = 4;
  localparam int BTN_ESC   = 5;
  localparam int BTN_MODE  = 6;
  localparam int NUM_BTN   = 7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector: one-cycle pulse per rising level.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic lvl,
  output logic pulse
);

  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= lvl;
      pulse <= lvl & ~prev;
    end
  end

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch mode sequencer: mode stepping, button forwarding, display mux and
// alarm ring arbitration. Snooze support is built only with WATCH_SNOOZE_EN.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int NUM_MODES    = 4,
  parameter int RING_TICKS   = 60,
  parameter int SNOOZE_TICKS = 300
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic                        btn_enter,
  input  logic                        btn_esc,
  input  logic                        btn_mode,
  input  logic                        sec_tick,
  input  logic                        alm_req,
  input  logic [NUM_MODES-1:0]        busy,
  input  logic [DISP_W*NUM_MODES-1:0] disp_in,
  output logic [NUM_MODES-1:0]        mode_sel,
  output logic                        up,
  output logic                        down,
  output logic                        left,
  output logic                        right,
  output logic                        enter,
  output logic                        esc,
  output logic [DISP_W-1:0]           out,
  output logic                        buzzer,
  output logic                        ring_ack
);

  localparam int CUR_W   = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int CNT_MAX = max_int(RING_TICKS, SNOOZE_TICKS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  watch_state_e      state;
  logic [CUR_W-1:0]  cur;
  logic [CUR_W-1:0]  next_cur;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              alm_prev;
  logic              alm_rise;
  logic              fwd_en;
  logic              ring_done;
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] pulse;
  logic [DISP_W-1:0] slice [NUM_MODES];
  logic [DISP_W-1:0] sel_word;

  assign lvl = {btn_mode, btn_esc, btn_enter, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_edge u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .lvl   (lvl[i]),
      .pulse (pulse[i])
    );
  end

  for (genvar i = 0; i < NUM_MODES; i++) begin : g_slice
    assign slice[i] = disp_in[DISP_W*i +: DISP_W];
  end

  // Buttons reach the active mode only when the alarm is not ringing.
  assign fwd_en = (state != RING);
  assign up     = pulse[BTN_UP]    & fwd_en;
  assign down   = pulse[BTN_DOWN]  & fwd_en;
  assign left   = pulse[BTN_LEFT]  & fwd_en;
  assign right  = pulse[BTN_RIGHT] & fwd_en;
  assign enter  = pulse[BTN_ENTER] & fwd_en;
  assign esc    = pulse[BTN_ESC]   & fwd_en;

  assign alm_rise  = alm_req & ~alm_prev;
  assign ring_done = sec_tick && (cnt == CNT_W'(RING_TICKS - 1));

  // NOTE: every always_comb target gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_cur = cur + 1'b1;
    if (cur == CUR_W'(NUM_MODES - 1)) next_cur = '0;
    cnt_inc = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + 1'b1;
    sel_word = (state == RING) ? slice[MODE_CLOCK] : slice[cur];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORM;
      cur      <= '0;
      mode_sel <= NUM_MODES'(1);
      cnt      <= '0;
      alm_prev <= 1'b0;
      buzzer   <= 1'b0;
      ring_ack <= 1'b0;
    end else begin
      alm_prev <= alm_req;
      ring_ack <= 1'b0;
      unique case (state)
        NORM: begin
          // An alarm rise pre-empts a coincident mode pulse.
          if (alm_rise) begin
            state  <= RING;
            buzzer <= 1'b1;
            cnt    <= '0;
          end else if (pulse[BTN_MODE] && !busy[cur]) begin
            cur      <= next_cur;
            mode_sel <= NUM_MODES'(1) << next_cur;
          end
        end
        RING: begin
          if (pulse[BTN_ESC] || ring_done) begin
            state    <= NORM;
            buzzer   <= 1'b0;
            ring_ack <= 1'b1;
            cnt      <= '0;
`ifdef WATCH_SNOOZE_EN
          end else if (pulse[BTN_ENTER]) begin
            state  <= SNOOZE;
            buzzer <= 1'b0;
            cnt    <= '0;
`endif
          end else if (sec_tick) begin
            cnt <= cnt_inc;
          end
        end
`ifdef WATCH_SNOOZE_EN
        SNOOZE: begin
          if (pulse[BTN_ESC]) begin
            state    <= NORM;
            ring_ack <= 1'b1;
            cnt      <= '0;
          end else if (sec_tick && (cnt == CNT_W'(SNOOZE_TICKS - 1))) begin
            state  <= RING;
            buzzer <= 1'b1;
            cnt    <= '0;
          end else if (sec_tick) begin
            cnt <= cnt_inc;
          end
        end
`endif
        default: begin
          state  <= NORM;
          buzzer <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= sel_word;
  end

endmodule

// File: doc/watch_mode_ctrl.md
# watch_mode_ctrl

Top-level mode sequencer for the watch. It turns debounced button levels into one-cycle pulses, owns the current-mode index and drives a one-hot mode-select bus to the clock, alarm, stopwatch and timer sub-modules. It muxes their 48-bit display words onto the single display output. It also arbitrates the display and buttons away from the active mode while the alarm rings.

## Interface
- NUM_MODES, 4, number of display/edit modes (index 0 is the clock face)
- RING_TICKS, 60, sec_tick pulses before an unacknowledged ring self-clears
- SNOOZE_TICKS, 300, sec_tick pulses of snooze (only with WATCH_SNOOZE_EN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_up, btn_down, btn_left, btn_right, btn_enter, btn_esc, btn_mode  in  1 each  debounced button levels, synchronous to clk
- sec_tick  in  1  one-cycle pulse per second
- alm_req  in  1  alarm-match level from the alarm block
- busy  in  NUM_MODES  per-mode "editing in progress" flags
- disp_in  in  48*NUM_MODES  display words; mode i occupies bits [48*i+47:48*i]
- mode_sel  out  NUM_MODES  one-hot current mode
- up, down, left, right, enter, esc  out  1 each  forwarded button pulses
- out  out  48  registered display word
- buzzer  out  1  ring indicator
- ring_ack  out  1  one-cycle pulse that clears the alarm block's request

## Operation
- Each button is edge-detected. A rising level produces exactly one 1-cycle pulse, and holding the button produces no further pulses.
- The state register uses the NORM, RING and SNOOZE states. SNOOZE exists only with the macro.
- NORM behaviour:
  - A mode pulse with busy[cur]==0 advances cur: cur+1, wrapping from NUM_MODES-1 to 0. A mode pulse is ignored while busy[cur]==1.
  - The other six pulses are forwarded to the matching outputs.
  - out follows the disp_in slice selected by cur.
- NORM→RING occurs on a rising edge of alm_req. A level that stays high after an acknowledge never re-triggers a ring.
- RING behaviour:
  - buzzer=1.
  - All forwarded pulses are held at 0.
  - out shows slice 0 (the clock face).
  - cur is unchanged, and mode pulses are discarded.
  - A ring counter counts sec_tick pulses.
- RING→NORM occurs on an esc pulse or when the counter reaches RING_TICKS. ring_ack pulses once, buzzer drops and the counter clears.
- Simultaneous events:
  - An alm_req rise in the same cycle as a mode pulse: RING wins and the mode pulse is dropped.
  - esc in the same cycle as the timeout: a single ring_ack.
  - An alm_req rise while in RING or SNOOZE is ignored.
- Counter width is $clog2(max(RING_TICKS,SNOOZE_TICKS)+1). The counter saturates and does not wrap.
- Asynchronous reset, including mid-ring or mid-snooze, forces every output to its reset value and discards any snooze in progress.

## Timing
- Reset values: state=NORM, cur=0, mode_sel=1 (bit 0 set), all pulse outputs 0, out=48'h0, buzzer=0, ring_ack=0, counters 0.
- Button level rise at cycle n produces the forwarded pulse at cycle n+1.
- A mode pulse at n+1 gives the new mode_sel at n+2 and the new out at n+3.
- An alm_req rise at cycle n gives state RING and buzzer=1 at n+1.
- An esc pulse in RING at cycle n gives buzzer=0 and ring_ack=1 at cycle n+1. ring_ack is exactly 1 cycle wide.
- Timeout: the RING_TICKS-th sec_tick in RING at cycle n gives ring_ack=1 and buzzer=0 at n+1.
- out is registered from the disp_in slice with one cycle of latency.

## Configuration
- WATCH_SNOOZE_EN defined:
  - An enter pulse in RING moves to SNOOZE, with buzzer=0, no ring_ack and the counter cleared.
  - In SNOOZE, the display and buttons behave as in NORM, but mode pulses are ignored.
  - After SNOOZE_TICKS sec_ticks the block returns to RING with a fresh RING_TICKS count.
  - An esc pulse in SNOOZE issues ring_ack and moves to NORM.
- WATCH_SNOOZE_EN undefined:
  - The SNOOZE state and its counter logic are absent.
  - An enter pulse in RING is discarded.

## Structure
- The shared package watch_pkg holds:
  - the state enum (NORM, RING, SNOOZE);
  - DISP_W=48;
  - the mode indices MODE_CLOCK=0, MODE_ALARM=1, MODE_STOPWATCH=2, MODE_TIMER=3.
- The sub-module btn_edge is the registered rising-edge detector, with ports clk, rst_n, lvl and pulse. It is instantiated once per button.

## Test plan
- Reset then press btn_mode 4 times, busy=0 → mode_sel steps 0001→0010→0100→1000→0001, and out tracks each slice with 1-cycle latency.
- Set cur=1 (alarm mode) with busy=4'b0010, then press btn_mode → mode_sel stays 0010. Clearing busy and pressing again → 0100.
- Raise alm_req in mode 2, then hold btn_up → buzzer=1, up stays 0 and out=slice 0. An esc press → one ring_ack pulse, buzzer=0, mode_sel still 0100.
- Keep alm_req high with no esc and apply 60 sec_ticks → ring_ack on the cycle after the 60th tick, and no re-ring while alm_req remains high.
- Apply an alm_req rise and a btn_mode pulse in the same cycle → RING, and mode_sel unchanged after the ack. Assert rst_n low mid-ring → buzzer=0, mode_sel=0001 immediately.
- With WATCH_SNOOZE_EN, press enter in RING → buzzer=0 with no ack. After 300 sec_ticks, buzzer=1 again. An esc press then → ring_ack.
